// File: rtl/pipeline_stage_decode.sv
// Decode stage: register file with write-through bypass, load-use hazard detection
// and a registered decode bundle that is handed to execute one cycle after fetch.
module pipeline_stage_decode #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fetchValid,
  input  logic [XLEN-1:0] fetchProgramCounter,
  input  logic [4:0]      fetchRs1,
  input  logic [4:0]      fetchRs2,
  input  logic            fetchUsesRs2,
  input  logic [4:0]      fetchRd,
  input  logic            fetchRegWrite,
  input  logic            fetchMemRead,
  input  logic            fetchMemWrite,
  input  logic [XLEN-1:0] fetchImmediate,
  input  logic            jumpEnabled,
  input  logic            wbEnable,
  input  logic [4:0]      wbRegister,
  input  logic [XLEN-1:0] wbValue,
  output logic            stallOnDecode,
  output logic            decodeValid,
  output logic [XLEN-1:0] decodeProgramCounter,
  output logic [4:0]      decodeRs1,
  output logic [4:0]      decodeRs2,
  output logic [4:0]      decodeRd,
  output logic            decodeRegWrite,
  output logic            decodeMemRead,
  output logic            decodeMemWrite,
  output logic [XLEN-1:0] decodeOperand1,
  output logic [XLEN-1:0] decodeOperand2,
  output logic [XLEN-1:0] decodeImmediate,
  output logic [15:0]     stallCycles
);

  // Handshake: fetchValid qualifies the fetch bundle; while stallOnDecode is high
  // the fetch stage must hold that bundle unchanged. decodeValid qualifies every
  // decode* field; execute has no back-pressure, so a bubble is simply decodeValid=0.

  logic [REG_COUNT-1:0][XLEN-1:0] regFile;
  logic [XLEN-1:0]                operand1;
  logic [XLEN-1:0]                operand2;
  logic                           wbActive;
  logic                           hazard;
  logic                           bubble;

  assign wbActive = wbEnable && (wbRegister != 5'd0);

  // x0 is never written, so reading it straight from the array always yields 0.
  always_comb begin
    operand1 = regFile[fetchRs1];
    operand2 = regFile[fetchRs2];
    if (wbActive && (wbRegister == fetchRs1)) operand1 = wbValue;
    if (wbActive && (wbRegister == fetchRs2)) operand2 = wbValue;
  end

  assign hazard = fetchValid && decodeValid && decodeMemRead && (decodeRd != 5'd0) &&
                  ((decodeRd == fetchRs1) || (fetchUsesRs2 && (decodeRd == fetchRs2)));

  assign stallOnDecode = hazard && !jumpEnabled;
  assign bubble        = jumpEnabled || stallOnDecode || !fetchValid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      regFile <= '0;
    end else if (wbActive) begin
      regFile[wbRegister] <= wbValue;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stallCycles <= 16'd0;
    end else if (stallOnDecode && (stallCycles != 16'hFFFF)) begin
      stallCycles <= stallCycles + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || bubble) begin
      decodeValid          <= 1'b0;
      decodeProgramCounter <= '0;
      decodeRs1            <= 5'd0;
      decodeRs2            <= 5'd0;
      decodeRd             <= 5'd0;
      decodeRegWrite       <= 1'b0;
      decodeMemRead        <= 1'b0;
      decodeMemWrite       <= 1'b0;
      decodeOperand1       <= '0;
      decodeOperand2       <= '0;
      decodeImmediate      <= '0;
    end else begin
      decodeValid          <= 1'b1;
      decodeProgramCounter <= fetchProgramCounter;
      decodeRs1            <= fetchRs1;
      decodeRs2            <= fetchRs2;
      decodeRd             <= fetchRd;
      decodeRegWrite       <= fetchRegWrite;
      decodeMemRead        <= fetchMemRead;
      decodeMemWrite       <= fetchMemWrite;
      decodeOperand1       <= operand1;
      decodeOperand2       <= operand2;
      decodeImmediate      <= fetchImmediate;
    end
  end

endmodule
